// File: rtl/reg_dump_sequencer.sv
// reg_dump_sequencer
// Walks the general-purpose registers through the register file debug read
// port and writes one "xNN: HHHHHHHH" text row per register into the VGA
// text buffer. Each register value is captured once into a shadow register,
// so the emitted row cannot change while it is being written out.

module reg_dump_sequencer #(
    parameter int NUM_REGS = 32,
    parameter int COLS     = 80,
    parameter int ROW_BASE = 0,
    parameter int TB_AW    = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [4:0]       rf_raddr,
    input  logic [31:0]      rf_rdata,
    output logic [3:0]       nib,
    input  logic [6:0]       asc_in,
    output logic             tb_we,
    output logic [TB_AW-1:0] tb_addr,
    output logic [6:0]       tb_data,
    input  logic             tb_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_LATCH,
        S_EMIT,
        S_NEXT,
        S_DONE
    } state_t;

    // Text address of the first row, and the step between rows. The step is
    // added each row instead of multiplying the register index by COLS.
    localparam logic [TB_AW-1:0] RA_INIT  = TB_AW'(ROW_BASE * COLS);
    localparam logic [TB_AW-1:0] ROW_STEP = TB_AW'(COLS);
    localparam logic [5:0]       NREGS    = 6'(NUM_REGS);
    localparam logic [3:0]       LAST_COL = 4'd12;
    localparam logic [3:0]       FIRST_HEX_COL = 4'd5;

    state_t            state_q, state_d;
    logic [5:0]        idx_q, idx_d;
    logic [3:0]        tens_q, tens_d;
    logic [3:0]        ones_q, ones_d;
    logic [TB_AW-1:0]  ra_q, ra_d;
    logic [3:0]        col_q, col_d;
    logic [31:0]       shadow_q, shadow_d;

    logic [5:0]        idx_inc;
    logic [3:0]        hex_nib;
    logic              emit_accept;
    logic              in_dump;

    assign idx_inc     = idx_q + 6'd1;
    assign emit_accept = (state_q == S_EMIT) && tb_ready;
    assign in_dump     = (state_q == S_RD) || (state_q == S_LATCH) ||
                         (state_q == S_EMIT) || (state_q == S_NEXT);

    // State and datapath registers; everything clears asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= 6'd0;
            tens_q   <= 4'd0;
            ones_q   <= 4'd0;
            ra_q     <= '0;
            col_q    <= 4'd0;
            shadow_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            tens_q   <= tens_d;
            ones_q   <= ones_d;
            ra_q     <= ra_d;
            col_q    <= col_d;
            shadow_q <= shadow_d;
        end
    end

    // Next-state logic: row walk, column advance on accepted writes, abort.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tens_d   = tens_q;
        ones_d   = ones_q;
        ra_d     = ra_q;
        col_d    = col_q;
        shadow_d = shadow_q;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_RD;
                    idx_d   = 6'd0;
                    tens_d  = 4'd0;
                    ones_d  = 4'd0;
                    ra_d    = RA_INIT;
                    col_d   = 4'd0;
                end
            end
            S_RD: begin
                state_d = S_LATCH;
            end
            S_LATCH: begin
                shadow_d = rf_rdata;
                state_d  = S_EMIT;
            end
            S_EMIT: begin
                if (emit_accept) begin
                    if (col_q == LAST_COL) begin
                        col_d   = 4'd0;
                        state_d = S_NEXT;
                    end else begin
                        col_d = col_q + 4'd1;
                    end
                end
            end
            S_NEXT: begin
                idx_d = idx_inc;
                ra_d  = ra_q + ROW_STEP;
                if (ones_q == 4'd9) begin
                    ones_d = 4'd0;
                    tens_d = tens_q + 4'd1;
                end else begin
                    ones_d = ones_q + 4'd1;
                end
                if (idx_inc < NREGS) begin
                    state_d = S_RD;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            col_d   = 4'd0;
        end
    end

    // Nibble selection for the hex digits, most significant nibble first.
    always_comb begin
        hex_nib = 4'd0;
        case (col_q)
            4'd5:    hex_nib = shadow_q[31:28];
            4'd6:    hex_nib = shadow_q[27:24];
            4'd7:    hex_nib = shadow_q[23:20];
            4'd8:    hex_nib = shadow_q[19:16];
            4'd9:    hex_nib = shadow_q[15:12];
            4'd10:   hex_nib = shadow_q[11:8];
            4'd11:   hex_nib = shadow_q[7:4];
            4'd12:   hex_nib = shadow_q[3:0];
            default: hex_nib = 4'd0;
        endcase
    end

    // Outputs decoded from registered state only (plus the converter result),
    // so they hold steady for the whole cycle and clear with reset.
    always_comb begin
        busy     = in_dump;
        done     = (state_q == S_DONE);
        rf_raddr = 5'd0;
        nib      = 4'd0;
        tb_we    = 1'b0;
        tb_addr  = '0;
        tb_data  = 7'd0;

        if (in_dump) begin
            rf_raddr = idx_q[4:0];
        end

        if (state_q == S_EMIT) begin
            tb_we   = 1'b1;
            tb_addr = ra_q + TB_AW'(col_q);
            if (col_q >= FIRST_HEX_COL) begin
                nib     = hex_nib;
                tb_data = asc_in;
            end else begin
                case (col_q)
                    4'd0:    tb_data = 7'h78;
                    4'd1:    tb_data = 7'h30 + {3'b000, tens_q};
                    4'd2:    tb_data = 7'h30 + {3'b000, ones_q};
                    4'd3:    tb_data = 7'h3A;
                    4'd4:    tb_data = 7'h20;
                    default: tb_data = 7'h00;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_reg_dump_sequencer.sv
// Testbench for reg_dump_sequencer: register file, hex converter and text
// buffer models around the DUT, table-driven row checks and hand-written
// sequences for backpressure, abort, reset and shadow capture.

module tb_reg_dump_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        busy;
    logic        done;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic [3:0]  nib;
    logic [6:0]  asc_in;
    logic        tb_we;
    logic [11:0] tb_addr;
    logic [6:0]  tb_data;
    logic        tb_ready;

    logic [31:0] regs [0:31];
    logic [6:0]  tbuf [0:4095];
    logic        clear_req = 1'b0;

    int checks     = 0;
    int errors     = 0;
    int done_count = 0;

    logic [11:0] bp_addr_seen;
    logic [6:0]  bp_data_seen;
    logic [3:0]  bp_nib_seen;
    logic        bp_fired;
    logic        bp_unstable;

    typedef struct {
        string       name;
        logic [11:0] addr;
        logic [6:0]  exp;
    } vec_t;

    vec_t vecs [$];

    reg_dump_sequencer #(
        .NUM_REGS (32),
        .COLS     (80),
        .ROW_BASE (0),
        .TB_AW    (12)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .rf_raddr (rf_raddr),
        .rf_rdata (rf_rdata),
        .nib      (nib),
        .asc_in   (asc_in),
        .tb_we    (tb_we),
        .tb_addr  (tb_addr),
        .tb_data  (tb_data),
        .tb_ready (tb_ready)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    // Register file debug port: data valid one cycle after the address.
    always @(posedge clk) rf_rdata <= regs[rf_raddr];

    // Nibble to ASCII hex converter (uppercase).
    always_comb asc_in = (nib < 4'd10) ? (7'h30 + {3'b000, nib}) : (7'h37 + {3'b000, nib});

    // Text buffer: stores accepted writes, wiped on request.
    always @(posedge clk) begin
        if (clear_req) begin
            for (int a = 0; a < 4096; a++) tbuf[a] <= 7'h00;
        end else if (tb_we && tb_ready) begin
            tbuf[tb_addr] <= tb_data;
        end
    end

    // Counts every done pulse seen by the bench.
    always @(posedge clk) if (done) done_count <= done_count + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Drive inputs at a falling edge and advance to the next falling edge.
    task automatic applyStimulus(input logic s, input logic a, input logic r);
        start    = s;
        abort    = a;
        tb_ready = r;
        @(negedge clk);
    endtask

    task automatic addRow(input string tag, input int addr, input string s);
        for (int k = 0; k < s.len(); k++) begin
            vec_t v;
            v.name = $sformatf("%s_c%0d", tag, k);
            v.addr = 12'(addr + k);
            v.exp  = 7'(s[k]);
            vecs.push_back(v);
        end
    endtask

    task automatic checkTable();
        foreach (vecs[k]) begin
            checkOutput(vecs[k].name, {25'd0, tbuf[vecs[k].addr]}, {25'd0, vecs[k].exp});
        end
        vecs.delete();
    endtask

    // Runs one full dump from IDLE and returns cycles from busy rising to done.
    // mode 1 stalls row 2 column 7 for ten cycles; mode 2 rewrites x7 after
    // its row has started emitting.
    task automatic runDump(input int mode, output int cycles);
        int  bp_left;
        bit  finished;
        bit  hooked;
        bp_left     = 0;
        finished    = 1'b0;
        hooked      = 1'b0;
        bp_fired    = 1'b0;
        bp_unstable = 1'b0;
        cycles      = 0;
        applyStimulus(1'b1, 1'b0, 1'b1);
        start = 1'b0;
        checkOutput("busy_rise", {31'd0, busy}, 32'd1);
        for (int k = 0; k < 3000 && !finished; k++) begin
            if (bp_left > 0) begin
                if (tb_addr !== bp_addr_seen || tb_data !== bp_data_seen ||
                    nib !== bp_nib_seen || tb_we !== 1'b1) begin
                    bp_unstable = 1'b1;
                end
                bp_left--;
                if (bp_left == 0) tb_ready = 1'b1;
            end else if (mode == 1 && !bp_fired && tb_we && tb_addr == 12'd167) begin
                bp_addr_seen = tb_addr;
                bp_data_seen = tb_data;
                bp_nib_seen  = nib;
                bp_fired     = 1'b1;
                tb_ready     = 1'b0;
                bp_left      = 10;
            end
            if (mode == 2 && !hooked && tb_we && tb_addr == 12'd560) begin
                regs[7] = 32'hFFFF_FFFF;
                hooked  = 1'b1;
            end
            @(negedge clk);
            cycles++;
            if (done) finished = 1'b1;
        end
        checkOutput("dump_finished", {31'd0, finished}, 32'd1);
        checkOutput("busy_low_at_done", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int         cyc;
        bit         found;
        int         dc;
        logic [6:0] x5_bytes [13];

        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        tb_ready = 1'b1;
        for (int r = 0; r < 32; r++) regs[r] = 32'd0;

        // Reset values while rst_n is held low.
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_we", {31'd0, tb_we}, 32'd0);
        checkOutput("rst_addr", {20'd0, tb_addr}, 32'd0);
        checkOutput("rst_data", {25'd0, tb_data}, 32'd0);
        checkOutput("rst_raddr", {27'd0, rf_raddr}, 32'd0);
        checkOutput("rst_nib", {28'd0, nib}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] full dump, all registers zero");
        runDump(0, cyc);
        checkOutput("full_cycles", cyc, 32'd512);
        clear_req = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1);
        clear_req = 1'b0;
        checkOutput("done_one_cycle", {31'd0, done}, 32'd0);
        checkOutput("idle_after_done", {31'd0, busy}, 32'd0);
        // The buffer was wiped after the dump, so check rows on a fresh dump.
        runDump(0, cyc);
        addRow("row0", 0, "x00: 00000000");
        addRow("row9", 720, "x09:");
        addRow("row10", 800, "x10:");
        addRow("row31", 2480, "x31:");
        checkTable();

        $display("[TB] x5 content and x7 shadow capture");
        regs[5] = 32'hDEAD_BEEF;
        regs[7] = 32'h1234_5678;
        clear_req = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1);
        clear_req = 1'b0;
        runDump(2, cyc);
        checkOutput("shadow_cycles", cyc, 32'd512);
        x5_bytes = '{7'h78, 7'h30, 7'h35, 7'h3A, 7'h20, 7'h44, 7'h45,
                     7'h41, 7'h44, 7'h42, 7'h45, 7'h45, 7'h46};
        for (int k = 0; k < 13; k++) begin
            vec_t v;
            v.name = $sformatf("x5_c%0d", k);
            v.addr = 12'(400 + k);
            v.exp  = x5_bytes[k];
            vecs.push_back(v);
        end
        addRow("x7", 560, "x07: 12345678");
        checkTable();

        $display("[TB] backpressure at row 2 column 7");
        regs[2] = 32'hA1B2_C3D4;
        applyStimulus(1'b0, 1'b0, 1'b1);
        runDump(1, cyc);
        checkOutput("bp_cycles", cyc, 32'd522);
        checkOutput("bp_fired", {31'd0, bp_fired}, 32'd1);
        checkOutput("bp_addr", {20'd0, bp_addr_seen}, 32'd167);
        checkOutput("bp_data", {25'd0, bp_data_seen}, 32'h42);
        checkOutput("bp_nib", {28'd0, bp_nib_seen}, 32'hB);
        checkOutput("bp_stable", {31'd0, bp_unstable}, 32'd0);
        addRow("x2", 160, "x02: A1B2C3D4");
        checkTable();

        $display("[TB] start and abort together in idle");
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("start_abort_idle_busy", {31'd0, busy}, 32'd0);
        checkOutput("start_abort_idle_we", {31'd0, tb_we}, 32'd0);

        $display("[TB] start while busy, then abort");
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("sb_busy", {31'd0, busy}, 32'd1);
        found = 1'b0;
        for (int k = 0; k < 600 && !found; k++) begin
            if (tb_we && tb_addr == 12'd240) found = 1'b1;
            else applyStimulus(1'b0, 1'b0, 1'b1);
        end
        checkOutput("reach_row3", {31'd0, found}, 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("sb_raddr", {27'd0, rf_raddr}, 32'd3);
        checkOutput("sb_addr", {20'd0, tb_addr}, 32'd241);
        checkOutput("sb_still_busy", {31'd0, busy}, 32'd1);
        found = 1'b0;
        for (int k = 0; k < 600 && !found; k++) begin
            if (tb_we && tb_addr == 12'd325) found = 1'b1;
            else applyStimulus(1'b0, 1'b0, 1'b1);
        end
        checkOutput("reach_row4", {31'd0, found}, 32'd1);
        dc = done_count;
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_we", {31'd0, tb_we}, 32'd0);
        checkOutput("abort_addr", {20'd0, tb_addr}, 32'd0);
        for (int k = 0; k < 20; k++) applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("abort_no_done", done_count, dc);
        checkOutput("abort_stays_idle", {31'd0, busy}, 32'd0);

        $display("[TB] reset mid-row for x12");
        regs[12] = 32'h89AB_CDEF;
        applyStimulus(1'b1, 1'b0, 1'b1);
        found = 1'b0;
        for (int k = 0; k < 600 && !found; k++) begin
            if (tb_we && tb_addr == 12'd966) found = 1'b1;
            else applyStimulus(1'b0, 1'b0, 1'b1);
        end
        checkOutput("reach_row12", {31'd0, found}, 32'd1);
        checkOutput("pre_rst_nib", {28'd0, nib}, 32'h9);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_busy", {31'd0, busy}, 32'd0);
        checkOutput("arst_we", {31'd0, tb_we}, 32'd0);
        checkOutput("arst_addr", {20'd0, tb_addr}, 32'd0);
        checkOutput("arst_data", {25'd0, tb_data}, 32'd0);
        checkOutput("arst_nib", {28'd0, nib}, 32'd0);
        checkOutput("arst_raddr", {27'd0, rf_raddr}, 32'd0);
        checkOutput("arst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b1);
        start = 1'b0;
        checkOutput("restart_busy", {31'd0, busy}, 32'd1);
        checkOutput("restart_raddr", {27'd0, rf_raddr}, 32'd0);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (tb_we) found = 1'b1;
            else applyStimulus(1'b0, 1'b0, 1'b1);
        end
        checkOutput("restart_emit", {31'd0, found}, 32'd1);
        checkOutput("restart_addr", {20'd0, tb_addr}, 32'd0);
        checkOutput("restart_data", {25'd0, tb_data}, 32'h78);
        found = 1'b0;
        for (int k = 0; k < 700 && !found; k++) begin
            if (done) found = 1'b1;
            else applyStimulus(1'b0, 1'b0, 1'b1);
        end
        checkOutput("restart_done", {31'd0, found}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_dump_sequencer.md
# reg_dump_sequencer

Walks the 32 RISC-V general-purpose registers and writes a hex dump of each one into the VGA text buffer, one text row per register, in the form `xNN: HHHHHHHH`. It drives the register file's debug read port and feeds nibbles to the nibble-to-ASCII hex converter. It also writes characters to the text buffer through a ready/valid write port that is shared with other VGA writers.

## Interface
Parameters:
- NUM_REGS, 32, registers dumped (x0..x(NUM_REGS-1)), 1..32
- COLS, 80, characters per text row
- ROW_BASE, 0, text row that receives x0
- TB_AW, 12, text-buffer address width

Ports:
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a full dump; sampled only in IDLE
- abort  in  1  synchronous cancel of a dump in progress
- busy  out  1  dump in progress
- done  out  1  one-cycle pulse when a dump completes normally
- rf_raddr  out  5  register-file debug read address
- rf_rdata  in  32  register-file read data, valid one cycle after rf_raddr
- nib  out  4  nibble to the hex-to-ASCII converter
- asc_in  in  7  converter output (combinational from nib)
- tb_we  out  1  text-buffer write request (valid)
- tb_addr  out  TB_AW  text-buffer character address
- tb_data  out  7  ASCII character to write
- tb_ready  in  1  write accepted when tb_we && tb_ready

## Operation
- States: IDLE, RD, LATCH, EMIT, NEXT, DONE.
- IDLE: start=1 moves to RD. On entry to RD: reg index i=0, label counters tens=0/ones=0, row address ra=ROW_BASE*COLS, col=0.
- RD: rf_raddr=i, held constant until NEXT. Next state is LATCH.
- LATCH: capture rf_rdata into a 32-bit shadow register. Next state is EMIT.
- EMIT: tb_we=1, tb_addr=ra+col, tb_data by column:
  - col0 = 0x78 'x'
  - col1 = 0x30+tens
  - col2 = 0x30+ones
  - col3 = 0x3A ':'
  - col4 = 0x20 ' '
  - col5..12 = asc_in, with nib = shadow[31-4*(col-5) -: 4], MSB nibble first
  - nib=0 outside col5..12
- EMIT handshake: on tb_we && tb_ready, col increments. An accept at col=12 moves to NEXT. With tb_ready=0, tb_addr, tb_data and nib hold stable.
- NEXT:
  - i+1; ra+COLS (no multiplier); ones+1, which wraps 9→0 and increments tens.
  - Go to RD if i+1 < NUM_REGS, else go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Shadow capture: the register is read once per row. Later changes to rf_rdata do not alter a row being emitted.
- start while busy: ignored.
- abort in any non-IDLE state: at the next edge go to IDLE, tb_we=0 and busy=0. No done pulse. Partially written text stays in the buffer. abort has priority over a simultaneous handshake accept.
- start and abort together in IDLE: abort wins, so the block stays in IDLE.
- busy=1 in RD, LATCH, EMIT and NEXT; busy=0 in IDLE and DONE.
- Reset values: busy 0, done 0, tb_we 0, tb_addr 0, tb_data 0, rf_raddr 0, nib 0, state IDLE.
- Outputs in IDLE: tb_addr=0 and tb_data=0.

## Timing
- start high at edge E0 means busy=1 and state RD in the following cycle.
- Per register with tb_ready=1: 16 cycles (RD 1, LATCH 1, EMIT 13, NEXT 1).
- Each cycle tb_ready=0 in EMIT adds one cycle.
- Full dump with NUM_REGS=32 and ready always high: done is high in the cycle 512 cycles after busy rises. busy falls on the same edge that done rises.
- The next start is accepted the cycle after done.
- tb_we, tb_addr, tb_data and nib come from registered state plus asc_in. They are stable for the whole EMIT cycle.
- rst_n low forces every output to its reset value immediately, without waiting for a clock edge, including mid-EMIT.
- On release of rst_n, the first rising edge with rst_n high evaluates IDLE.

## Test plan
- **x5 row content:** x5=0xDEADBEEF, ready=1, defaults, start. Addresses 400..412 must receive 0x78,0x30,0x35,0x3A,0x20,0x44,0x45,0x41,0x44,0x42,0x45,0x45,0x46.
- **Full-dump cycle count:** full dump with all registers 0. done must pulse exactly 512 cycles after busy rises. Row 0 must read "x00: 00000000" and row 31 must start at address 2480 with "x31:".
- **Backpressure:** hold tb_ready=0 for 10 cycles while at col 7. tb_addr, tb_data and nib must stay constant, and the total dump time must grow by exactly 10 cycles.
- **start while busy, then abort:** pulse start during the x3 row; there must be no restart. Then assert abort during EMIT; next cycle busy=0 and tb_we=0, and done never pulses.
- **Reset mid-dump:** drive rst_n low mid-EMIT for x12. All outputs must go to 0 without waiting for a clock edge. After release, a new start must dump x0 first.
- **Shadow capture:** change the x7 value from 0x12345678 to 0xFFFFFFFF after LATCH. Row 7 must still show "12345678".
